// File: rtl/input_controller_if.sv
// ============================================================================
// Module   : input_controller_if
// Brief    : Gamepad pin bundle between the poller and the off-chip 4021 pad.
// Options  : INPUT_CTRL_RAW_EN adds the active-high raw button mask.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface input_controller_if;
   logic       button_data_in;
   logic       latch_tb;
   logic       pulse_tb;
   logic       slow_clk_tb;
   logic [3:0] button_data_out_tb;
`ifdef INPUT_CTRL_RAW_EN
   logic [7:0] buttons_raw_tb;

   modport master (
      input  button_data_in,
      output latch_tb, pulse_tb, slow_clk_tb, button_data_out_tb, buttons_raw_tb
   );
   modport slave (
      output button_data_in,
      input  latch_tb, pulse_tb, slow_clk_tb, button_data_out_tb, buttons_raw_tb
   );
`else
   modport master (
      input  button_data_in,
      output latch_tb, pulse_tb, slow_clk_tb, button_data_out_tb
   );
   modport slave (
      output button_data_in,
      input  latch_tb, pulse_tb, slow_clk_tb, button_data_out_tb
   );
`endif
endinterface

`default_nettype wire

// File: rtl/input_controller.sv
// ============================================================================
// Module   : input_controller
// Brief    : NES gamepad (4021) poller: slow-clock divider, latch/pulse
//            sequencing, serial sampling and priority-encoded button code.
// Options  : INPUT_CTRL_RAW_EN exports buttons_raw_tb (active-high mask).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module input_controller #(
   parameter int CLK_DIV_HALF = 300,
   parameter int FRAME_TICKS  = 1389
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input_controller_if.master ctrl
);

   localparam int c_div_w  = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
   localparam int c_slot_w = 19;

   localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(CLK_DIV_HALF - 1);
   localparam logic [c_slot_w-1:0] c_slot_last  = c_slot_w'(FRAME_TICKS - 1);
   localparam logic [c_slot_w-1:0] c_slot_one   = c_slot_w'(1);
   localparam logic [c_slot_w-1:0] c_slot_dummy = c_slot_w'(8);
   localparam logic [c_slot_w-1:0] c_slot_idle0 = c_slot_w'(9);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_IDLE  = 2'd3
   } state_t;

   logic [c_div_w-1:0]  r_div_cnt;
   logic                r_slow_clk;
   state_t              r_state;
   logic [c_slot_w-1:0] r_slot;
   logic                r_latch;
   logic                r_pulse;
   logic [1:0]          r_sync;
   logic [7:0]          r_sample;
   logic [3:0]          r_code;

   logic                w_wrap;
   logic                w_rise;
   logic                w_fall;
   state_t              w_state_nxt;
   logic [c_slot_w-1:0] w_slot_nxt;
   logic                w_latch_nxt;
   logic                w_pulse_nxt;
   logic                w_sample_en;
   logic                w_load_out;
   logic [3:0]          w_code;

   assign w_wrap = (r_div_cnt == c_div_last);
   assign w_rise = w_wrap && !r_slow_clk;
   assign w_fall = w_wrap &&  r_slow_clk;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div_cnt  <= '0;
         r_slow_clk <= 1'b0;
      end else if (w_wrap) begin
         r_div_cnt  <= '0;
         r_slow_clk <= ~r_slow_clk;
      end else begin
         r_div_cnt  <= r_div_cnt + c_div_w'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_WAIT;
         r_slot  <= '0;
         r_latch <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
         r_latch <= w_latch_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   // Slot sequencing advances on rises; falls only drop the shift pulse and sample.
   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      w_latch_nxt = r_latch;
      w_pulse_nxt = r_pulse;
      w_sample_en = 1'b0;
      w_load_out  = 1'b0;
      if (w_rise) begin
         case (r_state)
            ST_WAIT: begin
               w_state_nxt = ST_LATCH;
               w_slot_nxt  = '0;
               w_latch_nxt = 1'b1;
               w_pulse_nxt = 1'b0;
            end
            ST_LATCH: begin
               w_state_nxt = ST_SHIFT;
               w_slot_nxt  = c_slot_one;
               w_latch_nxt = 1'b0;
               w_pulse_nxt = 1'b1;
            end
            ST_SHIFT: begin
               if (r_slot == c_slot_dummy) begin
                  w_state_nxt = ST_IDLE;
                  w_slot_nxt  = c_slot_idle0;
                  w_pulse_nxt = 1'b0;
                  w_load_out  = 1'b1;
               end else begin
                  w_slot_nxt  = r_slot + c_slot_one;
                  w_pulse_nxt = 1'b1;
               end
            end
            ST_IDLE: begin
               if (r_slot == c_slot_last) begin
                  w_state_nxt = ST_LATCH;
                  w_slot_nxt  = '0;
                  w_latch_nxt = 1'b1;
               end else begin
                  w_slot_nxt  = r_slot + c_slot_one;
               end
            end
            default: begin
               w_state_nxt = ST_WAIT;
               w_slot_nxt  = '0;
               w_latch_nxt = 1'b0;
               w_pulse_nxt = 1'b0;
            end
         endcase
      end else if (w_fall) begin
         w_pulse_nxt = 1'b0;
         // The s8 pulse only flushes the shifter and is never sampled.
         if ((r_state == ST_LATCH) || ((r_state == ST_SHIFT) && (r_slot != c_slot_dummy)))
            w_sample_en = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync   <= 2'b11;
         r_sample <= 8'hFF;
      end else begin
         r_sync <= {r_sync[0], ctrl.button_data_in};
         if (w_sample_en)
            r_sample[r_slot[2:0]] <= r_sync[1];
      end
   end

   // Lowest-index pressed button wins, so scan from Right down to A.
   always_comb begin
      w_code = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!r_sample[i])
            w_code = 4'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_code <= 4'd0;
      else if (w_load_out)
         r_code <= w_code;
   end

`ifdef INPUT_CTRL_RAW_EN
   logic [7:0] r_raw;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_raw <= 8'h00;
      else if (w_load_out)
         r_raw <= ~r_sample;
   end

   assign ctrl.buttons_raw_tb = r_raw;
`endif

   assign ctrl.latch_tb           = r_latch;
   assign ctrl.pulse_tb           = r_pulse;
   assign ctrl.slow_clk_tb        = r_slow_clk;
   assign ctrl.button_data_out_tb = r_code;

endmodule

`default_nettype wire

// File: tb/tb_input_controller.sv
// ============================================================================
// Module   : tb_input_controller
// Brief    : Self-checking bench for input_controller against a timing model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_input_controller;

   localparam int DIV  = 4;
   localparam int FT   = 12;
   localparam int SLOW = 2 * DIV;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   input_controller_if ctrl_if ();

   input_controller #(
      .CLK_DIV_HALF (DIV),
      .FRAME_TICKS  (FT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (ctrl_if)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         t        = 0;
   int         n_pulse_hi;
   int         n_latch_hi;
   logic [7:0] next_mask = 8'h00;
   logic [7:0] cur_mask  = 8'h00;
   logic       s8_val    = 1'b1;
   logic [7:0] exp_code  = 8'h00;
   logic [7:0] exp_raw   = 8'h00;

   function automatic logic [7:0] prio(input logic [7:0] m);
      for (int i = 0; i < 8; i++)
         if (m[i]) return 8'(i + 1);
      return 8'h00;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp_v, t);
      end
   endtask

   // One clk cycle: drive the pad line as the gamepad would, advance the
   // timing model, then compare every output just after the edge.
   task automatic tick();
      int   u, ph, slot;
      logic e_slow, e_latch, e_pulse;
      @(posedge clk);
      t++;
      u = t - DIV;
      e_slow = 1'b0; e_latch = 1'b0; e_pulse = 1'b0;
      if (u >= 0) begin
         ph   = u % SLOW;
         slot = (u / SLOW) % FT;
         if (ph == 0) begin
            if (slot == 0) cur_mask = next_mask;
            if (slot == 9) begin
               exp_code = prio(cur_mask);
               exp_raw  = cur_mask;
            end
            ctrl_if.button_data_in = 1'($urandom);
         end else if (ph == 1) begin
            if (slot <= 7)      ctrl_if.button_data_in = ~cur_mask[slot];
            else if (slot == 8) ctrl_if.button_data_in = s8_val;
         end else if (ph == DIV) begin
            ctrl_if.button_data_in = 1'($urandom);
         end
         e_slow  = (ph < DIV);
         e_latch = (slot == 0);
         e_pulse = (slot >= 1) && (slot <= 8) && (ph < DIV);
      end else begin
         ctrl_if.button_data_in = 1'($urandom);
      end
      #1;
      check("slow_clk", 8'(ctrl_if.slow_clk_tb), 8'(e_slow));
      check("latch", 8'(ctrl_if.latch_tb), 8'(e_latch));
      check("pulse", 8'(ctrl_if.pulse_tb), 8'(e_pulse));
      check("code", 8'(ctrl_if.button_data_out_tb), exp_code);
`ifdef INPUT_CTRL_RAW_EN
      check("raw", ctrl_if.buttons_raw_tb, exp_raw);
`endif
      if (ctrl_if.latch_tb === 1'b1) n_latch_hi++;
      if (ctrl_if.pulse_tb === 1'b1) n_pulse_hi++;
   endtask

   task automatic run_frame(input logic [7:0] mask, input logic s8v);
      next_mask  = mask;
      s8_val     = s8v;
      n_pulse_hi = 0;
      n_latch_hi = 0;
      repeat (SLOW * FT) tick();
      check("pulse_hi_cycles", 8'(n_pulse_hi), 8'(8 * DIV));
      check("latch_hi_cycles", 8'(n_latch_hi), 8'(SLOW));
   endtask

   initial begin
      logic [7:0] rmask;
      ctrl_if.button_data_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_slow_clk", 8'(ctrl_if.slow_clk_tb), 8'h00);
      check("rst_latch", 8'(ctrl_if.latch_tb), 8'h00);
      check("rst_pulse", 8'(ctrl_if.pulse_tb), 8'h00);
      check("rst_code", 8'(ctrl_if.button_data_out_tb), 8'h00);
      @(negedge clk);
      reset = 1'b1;
      t     = 0;

      run_frame(8'h00, 1'b1);
      check("code_none", 8'(ctrl_if.button_data_out_tb), 8'd0);
      run_frame(8'h04, 1'($urandom));
      check("code_select", 8'(ctrl_if.button_data_out_tb), 8'd3);
      run_frame(8'h04, 1'($urandom));
      check("code_select_held", 8'(ctrl_if.button_data_out_tb), 8'd3);
      run_frame(8'h00, 1'b1);
      check("code_release", 8'(ctrl_if.button_data_out_tb), 8'd0);
      run_frame(8'h81, 1'($urandom));
      check("code_a_right", 8'(ctrl_if.button_data_out_tb), 8'd1);
      run_frame(8'h80, 1'($urandom));
      check("code_right", 8'(ctrl_if.button_data_out_tb), 8'd8);
      run_frame(8'h00, 1'b0);
      check("code_dummy_s8", 8'(ctrl_if.button_data_out_tb), 8'd0);

      for (int f = 0; f < 6; f++) begin
         rmask = 8'($urandom) & ~8'((9'd1 << $urandom_range(0, 7)) - 9'd1);
         run_frame(rmask, 1'($urandom));
      end

      run_frame(8'h50, 1'($urandom));
      check("code_up_left", 8'(ctrl_if.button_data_out_tb), 8'd5);
`ifdef INPUT_CTRL_RAW_EN
      check("raw_up_left", ctrl_if.buttons_raw_tb, 8'h50);
`endif

      // Abort a frame in the middle of s4 while the shift pulse is high.
      next_mask = 8'h02;
      repeat (DIV + 4 * SLOW + 2) tick();
      #2;
      reset = 1'b0;
      #1;
      check("abort_slow_clk", 8'(ctrl_if.slow_clk_tb), 8'h00);
      check("abort_latch", 8'(ctrl_if.latch_tb), 8'h00);
      check("abort_pulse", 8'(ctrl_if.pulse_tb), 8'h00);
      check("abort_code", 8'(ctrl_if.button_data_out_tb), 8'h00);
`ifdef INPUT_CTRL_RAW_EN
      check("abort_raw", ctrl_if.buttons_raw_tb, 8'h00);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset    = 1'b1;
      t        = 0;
      exp_code = 8'h00;
      exp_raw  = 8'h00;
      next_mask = 8'h08;
      repeat (DIV - 1) tick();
      check("latch_pre_first_rise", 8'(ctrl_if.latch_tb), 8'h00);
      tick();
      check("latch_at_first_rise", 8'(ctrl_if.latch_tb), 8'h01);
      repeat (SLOW * FT - DIV) tick();
      check("code_after_abort", 8'(ctrl_if.button_data_out_tb), 8'd4);
      run_frame(8'h00, 1'b1);
      check("code_final_none", 8'(ctrl_if.button_data_out_tb), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
